cdac_loader: RTL
================

# cdac_loader

Sequencer and arbiter for the comparator threshold DAC serial port. It accepts parallel DAC words from two on-chip requesters, such as the power-up default loader and the slow-control path. It grants them round-robin and serializes the granted word onto DACCLK/DACDAT/DAC_ENB_B. The JTAG user-2 DAC path always has priority: the loader never starts, and abandons any transfer in progress, while JTAG owns the DAC.

## Interface
Parameters:
- DW, 12, DAC word width in bits; shifted MSB first.
- HALF, 2, CLK25 cycles per DACCLK half-period; legal range 1..15.

Ports:
- CLK25  in  1  system clock; all logic on its rising edge.
- RST_B  in  1  synchronous reset, active low.
- REQ0  in  1  requester 0 load request; level, held until ACK0.
- DATA0  in  DW  requester 0 word; must be stable while REQ0 is high.
- ACK0  out  1  one-cycle pulse: requester 0 word fully loaded.
- REQ1  in  1  requester 1 load request; level.
- DATA1  in  DW  requester 1 word.
- ACK1  out  1  one-cycle pulse for requester 1.
- JTAG_BUSY  in  1  JTAG DAC path active (SHIFT & SEL2 & function 4), already synchronous to CLK25.
- BUSY  out  1  high in every state except IDLE.
- DACCLK  out  1  DAC serial clock; the DAC samples on the rising edge.
- DACDAT  out  1  DAC serial data.
- DAC_ENB_B  out  1  DAC chip enable, active low.
- XFER_CNT  out  8  count of completed transfers; wraps 255 to 0.

## Operation
- All outputs are registered. Values under reset: ACK0=ACK1=0, BUSY=0, DACCLK=0, DACDAT=0, DAC_ENB_B=1, XFER_CNT=0, state=IDLE, round-robin pointer=1 (so requester 0 wins first).
- States: IDLE, SETUP, CLK_LO, CLK_HI, HOLD, DONE. A half-period counter (4 bits) and a bit counter (ceil(log2(DW+1)) bits) drive the transitions.
- IDLE: a grant requires JTAG_BUSY=0 and at least one REQ high.
  - With a single requester, that requester is granted.
  - With both requesting, the one not granted last is granted. The pointer updates only on completion (DONE).
  - On grant: latch the DATA word into the shift register, record the grant id, go to SETUP.
- SETUP: DAC_ENB_B=0 and DACCLK=0 for HALF cycles, then go to CLK_LO with bit counter=DW.
- CLK_LO: DACDAT=current MSB and DACCLK=0 for HALF cycles, then go to CLK_HI.
- CLK_HI: DACCLK=1 for HALF cycles.
  - On exit, shift the register left by one and decrement the bit counter.
  - If the counter reaches 0, go to HOLD; otherwise go to CLK_LO.
- HOLD: DACCLK=0, DACDAT=0, DAC_ENB_B=0 for HALF cycles, then go to DONE.
- DONE: single cycle.
  - DAC_ENB_B=1.
  - ACKn=1 for the granted requester.
  - XFER_CNT increments, wrapping.
  - Round-robin pointer takes the grant id.
  - Next state is IDLE.
- Abort: if JTAG_BUSY=1 in any state from SETUP to HOLD, the next cycle is IDLE.
  - Outputs on that cycle: DAC_ENB_B=1, DACCLK=0, DACDAT=0.
  - No ACK is issued, XFER_CNT is unchanged and the pointer is unchanged.
  - The request is still pending and restarts from bit DW-1 once JTAG_BUSY=0.
  - JTAG_BUSY in DONE has no effect; that transfer has already completed.
- Requester rule: REQn must be low by the cycle after ACKn. If REQn is still high in IDLE, it is treated as a new request.
- A REQ that drops before its grant is simply not granted. A REQ that drops after its grant does not affect the transfer in progress.

## Timing
- Grant latency: REQ high in an IDLE cycle gives BUSY=1 and DAC_ENB_B=0 on the next clock edge.
- DAC_ENB_B low duration: HALF + 2·HALF·DW + HALF cycles. With the defaults this is 52 cycles.
- DONE (ACK high) follows immediately after the enable-low window.
- Back-to-back transfers: one IDLE cycle between DONE and the next SETUP. Period = 52 + 2 = 54 cycles with the defaults.
- DACDAT is stable for HALF cycles before each DACCLK rising edge and for HALF cycles after it. No bit changes while DACCLK=1.
- Abort latency: JTAG_BUSY high gives DAC_ENB_B=1 one cycle later.
- Reset mid-transfer: the next cycle shows reset values, and no ACK is issued.

## Test plan
- Single load: REQ0 with DATA0=0xA5C. Required: 12 DACCLK rising edges with bits 1,0,1,0,0,1,0,1,1,1,0,0, DAC_ENB_B low for 52 cycles, ACK0 pulses once, XFER_CNT=1.
- Round-robin: REQ0 and REQ1 held together, with DATA0=0x111 and DATA1=0x222, each requester dropping REQ after its own ACK. Required: order 0x111 then 0x222, 54 cycles between the two ACKs.
- Round-robin repeat: after requester 0 and then requester 1 have each been served, REQ0 and REQ1 are raised together again. Required: 0x111 is served first.
- JTAG priority: JTAG_BUSY=1 while REQ1 is high. Required: BUSY stays 0 and DAC_ENB_B stays 1. After JTAG_BUSY falls, the transfer starts one cycle later.
- Abort: JTAG_BUSY pulsed during bit 5 of a transfer. Required: DAC_ENB_B=1 on the next cycle, no ACK, XFER_CNT unchanged. The full 12-bit transfer then restarts and ACKs.
- Reset and wrap: RST_B=0 mid-SHIFT gives all outputs at their reset values on the next cycle. Separately, 256 completed transfers bring XFER_CNT back to 0.

Source files
------------

// File: rtl/cdac_loader.sv
// cdac_loader: round-robin arbiter and serializer for the comparator
// threshold DAC serial port. Two on-chip requesters share the port; the
// JTAG DAC path (JTAG_BUSY) always wins and aborts any load in flight.
module cdac_loader #(
  parameter int DW   = 12,  // DAC word width, shifted MSB first
  parameter int HALF = 2    // CLK25 cycles per DACCLK half-period, 1..15
) (
  input  logic          CLK25,
  input  logic          RST_B,
  input  logic          REQ0,
  input  logic [DW-1:0] DATA0,
  output logic          ACK0,
  input  logic          REQ1,
  input  logic [DW-1:0] DATA1,
  output logic          ACK1,
  input  logic          JTAG_BUSY,
  output logic          BUSY,
  output logic          DACCLK,
  output logic          DACDAT,
  output logic          DAC_ENB_B,
  output logic [7:0]    XFER_CNT
);

  localparam int BW = $clog2(DW + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    CLK_LO = 3'd2,
    CLK_HI = 3'd3,
    HOLD   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      half_q, half_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic            gid_q, gid_d;     // requester currently being served
  logic            last_q, last_d;   // requester served by the last completed load
  logic [7:0]      xfer_d;
  logic            gnt;
  logic            half_done;
  logic            in_xfer;
  logic            ack0_d, ack1_d, busy_d, dacclk_d, dacdat_d, enb_b_d;

  assign half_done = (half_q == 4'(HALF - 1));
  assign in_xfer   = (state_q == SETUP) || (state_q == CLK_LO) ||
                     (state_q == CLK_HI) || (state_q == HOLD);

  // Next-state, counters, shifter and the next value of every registered output
  always_comb begin
    // NOTE: every signal assigned below gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    state_d = state_q;
    half_d  = half_q + 4'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    gid_d   = gid_q;
    last_d  = last_q;
    xfer_d  = XFER_CNT;
    gnt     = 1'b0;

    case (state_q)
      IDLE: begin
        half_d = '0;
        if (!JTAG_BUSY && (REQ0 || REQ1)) begin
          // Contention goes to the requester not served last
          gnt     = (REQ0 && REQ1) ? !last_q : REQ1;
          gid_d   = gnt;
          shift_d = gnt ? DATA1 : DATA0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (half_done) begin
          state_d = CLK_LO;
          half_d  = '0;
          bit_d   = BW'(DW);
        end
      end
      CLK_LO: begin
        if (half_done) begin
          state_d = CLK_HI;
          half_d  = '0;
        end
      end
      CLK_HI: begin
        if (half_done) begin
          half_d  = '0;
          shift_d = {shift_q[DW-2:0], 1'b0};
          bit_d   = bit_q - 1'b1;
          state_d = (bit_q == BW'(1)) ? HOLD : CLK_LO;
        end
      end
      HOLD: begin
        if (half_done) begin
          state_d = DONE;
          half_d  = '0;
          xfer_d  = XFER_CNT + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        half_d  = '0;
        last_d  = gid_q;
      end
      default: begin
        state_d = IDLE;
        half_d  = '0;
      end
    endcase

    // JTAG takeover abandons the load; the request stays pending
    if (in_xfer && JTAG_BUSY) begin
      state_d = IDLE;
      half_d  = '0;
      xfer_d  = XFER_CNT;
    end

    // Outputs are registered from the state being entered
    busy_d   = (state_d != IDLE);
    dacclk_d = (state_d == CLK_HI);
    enb_b_d  = !((state_d == SETUP) || (state_d == CLK_LO) ||
                 (state_d == CLK_HI) || (state_d == HOLD));
    dacdat_d = ((state_d == CLK_LO) || (state_d == CLK_HI)) ? shift_d[DW-1] : 1'b0;
    ack0_d   = (state_d == DONE) && !gid_d;
    ack1_d   = (state_d == DONE) &&  gid_d;
  end

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge CLK25) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!RST_B) begin
      state_q   <= IDLE;
      half_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      gid_q     <= 1'b0;
      last_q    <= 1'b1;
      XFER_CNT  <= '0;
      BUSY      <= 1'b0;
      DACCLK    <= 1'b0;
      DACDAT    <= 1'b0;
      DAC_ENB_B <= 1'b1;
      ACK0      <= 1'b0;
      ACK1      <= 1'b0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      gid_q     <= gid_d;
      last_q    <= last_d;
      XFER_CNT  <= xfer_d;
      BUSY      <= busy_d;
      DACCLK    <= dacclk_d;
      DACDAT    <= dacdat_d;
      DAC_ENB_B <= enb_b_d;
      ACK0      <= ack0_d;
      ACK1      <= ack1_d;
    end
  end

endmodule
